// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings and the register-address constants used by hazard detection.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_HALT     = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination is read by the instruction in ID. Writes to x0 never hazard.
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used && (rs1_addr == ex_rd_addr);
    assign rs2_hit  = rs2_used && (rs2_addr == ex_rd_addr);
    assign load_use = ex_mem_read && (ex_rd_addr != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional performance
// counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
//
// state    | meaning
// INIT     | flushing all stage registers to bubbles after reset
// RUN      | normal issue; redirect / load-use / memory-wait resolution
// MEM_WAIT | pipeline frozen until data memory completes
// HALT     | memory timeout; everything held, exit only via reset
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH  = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_flush_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int INIT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Halt when the wait count would reach MEM_TIMEOUT on this not-ready cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    ctrl_state_e       state, state_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_err, mem_err_nxt;
    logic              load_use;
    logic              frozen;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .rs1_addr    (id_rs1_addr_i),
        .rs2_addr    (id_rs2_addr_i),
        .rs1_used    (id_rs1_used_i),
        .rs2_used    (id_rs2_used_i),
        .ex_mem_read (ex_mem_read_i),
        .ex_rd_addr  (ex_rd_addr_i),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    assign frozen = ((state == ST_RUN) && mem_req_i && !mem_ready_i) ||
                    ((state == ST_MEM_WAIT) && !mem_ready_i);

    always_comb begin
        state_nxt      = state;
        init_cnt_nxt   = init_cnt;
        wait_cnt_nxt   = wait_cnt;
        mem_err_nxt    = mem_err;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b1;
        id_ex_write_o  = 1'b0;
        id_ex_flush_o  = 1'b1;
        ex_mem_write_o = 1'b0;
        mem_wb_flush_o = 1'b1;
        halted_o       = 1'b0;

        unique case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (frozen) begin
                    if_id_flush_o = 1'b0;
                    id_ex_flush_o = 1'b0;
                    if (state == ST_RUN) begin
                        state_nxt    = ST_MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else if ((MEM_TIMEOUT != 0) && (wait_cnt >= WAIT_LAST)) begin
                        state_nxt    = ST_HALT;
                        mem_err_nxt  = 1'b1;
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    pc_write_o     = 1'b1;
                    if_id_write_o  = 1'b1;
                    if_id_flush_o  = 1'b0;
                    id_ex_write_o  = 1'b1;
                    id_ex_flush_o  = 1'b0;
                    ex_mem_write_o = 1'b1;
                    mem_wb_flush_o = 1'b0;
                    // A redirect squashes the ID instruction, so its hazard is moot.
                    if (ex_redirect_i) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    assign mem_err_o = mem_err;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             run_like;

    assign run_like = (state == ST_RUN) || (state == ST_MEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (run_like && !pc_write_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (run_like && pc_write_o && ex_redirect_i && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: init flush, load-use, redirect,
// memory wait/timeout, and asynchronous reset behaviour.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f, halted, mem_err}
    localparam logic [8:0] V_INIT  = 9'b001_010_100;
    localparam logic [8:0] V_NORM  = 9'b110_101_000;
    localparam logic [8:0] V_LU    = 9'b000_111_000;
    localparam logic [8:0] V_REDIR = 9'b111_111_000;
    localparam logic [8:0] V_FRZ   = 9'b000_000_100;
    localparam logic [8:0] V_HALT  = 9'b001_010_111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1, rs2, rd;
    logic             u1, u2, ld, redir, req, rdy;
    logic             pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f, halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       ctl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.PIPE_DEPTH(4), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_addr_i  (rs1),
        .id_rs2_addr_i  (rs2),
        .id_rs1_used_i  (u1),
        .id_rs2_used_i  (u2),
        .ex_mem_read_i  (ld),
        .ex_rd_addr_i   (rd),
        .ex_redirect_i  (redir),
        .mem_req_i      (req),
        .mem_ready_i    (rdy),
        .pc_write_o     (pc_w),
        .if_id_write_o  (if_id_w),
        .if_id_flush_o  (if_id_f),
        .id_ex_write_o  (id_ex_w),
        .id_ex_flush_o  (id_ex_f),
        .ex_mem_write_o (ex_mem_w),
        .mem_wb_flush_o (mem_wb_f),
        .halted_o       (halted),
        .mem_err_o      (mem_err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    assign ctl = {pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f, halted, mem_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle by +1.
    task automatic apply(input logic [4:0] a1, input logic [4:0] a2, input logic e1,
                         input logic e2, input logic l, input logic [4:0] d,
                         input logic r, input logic q, input logic y);
        @(negedge clk);
        rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; ld = l; rd = d;
        redir = r; req = q; rdy = y;
        #1;
    endtask

    task automatic idle();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_and_init(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_init0"}, 32'(ctl), 32'(V_INIT));
        for (int i = 1; i < 4; i++) begin
            idle();
            chk({tag, "_init"}, 32'(ctl), 32'(V_INIT));
        end
        idle();
        chk({tag, "_first_fetch"}, 32'(ctl), 32'(V_NORM));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        u1 = 1'b0; u2 = 1'b0; ld = 1'b0; redir = 1'b0; req = 1'b0; rdy = 1'b0;
        idle();
        idle();
        chk("reset_ctl", 32'(ctl), 32'(V_INIT));
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        release_and_init("boot");

        // load-use on rs2, then the bubble has drained
        apply(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2", 32'(ctl), 32'(V_LU));
        apply(5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_release", 32'(ctl), 32'(V_NORM));
        apply(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1", 32'(ctl), 32'(V_LU));
        apply(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2_unused", 32'(ctl), 32'(V_NORM));
        apply(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_rd_x0", 32'(ctl), 32'(V_NORM));

        // redirect wins over a simultaneous load-use
        apply(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("redir_over_lu", 32'(ctl), 32'(V_REDIR));

        // three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk("mem_freeze", 32'(ctl), 32'(V_FRZ));
        end
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mem_release", 32'(ctl), 32'(V_NORM));
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("ready_no_req", 32'(ctl), 32'(V_NORM));
        chk("stall_cnt_mem", stall_cnt, PERF ? 32'd5 : 32'd0);
        chk("flush_cnt_1", flush_cnt, PERF ? 32'd1 : 32'd0);

        // release from MEM_WAIT with a redirect in the same cycle
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mem_freeze2", 32'(ctl), 32'(V_FRZ));
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("mem_release_redir", 32'(ctl), 32'(V_REDIR));

        // timeout: 8 freeze cycles then HALT
        for (int i = 0; i < 8; i++) begin
            apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk("timeout_freeze", 32'(ctl), 32'(V_FRZ));
        end
        idle();
        chk("halt_entry", 32'(ctl), 32'(V_HALT));
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("halt_sticky", 32'(ctl), 32'(V_HALT));
        chk("stall_cnt_halt", stall_cnt, PERF ? 32'd14 : 32'd0);
        chk("flush_cnt_2", flush_cnt, PERF ? 32'd2 : 32'd0);

        // reset pulse clears HALT and error
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("halt_reset", 32'(ctl), 32'(V_INIT));
        chk("halt_reset_flush_cnt", flush_cnt, 32'd0);
        release_and_init("rehalt");

        // asynchronous reset in the middle of MEM_WAIT
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mw_before_reset", 32'(ctl), 32'(V_FRZ));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 32'(ctl), 32'(V_INIT));
        chk("async_reset_stall_cnt", stall_cnt, 32'd0);
        release_and_init("post_async");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enables and bubble-inserts of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use hazards, EX-stage branch/jump redirects and multi-cycle data-memory waits.
- Pipeline registers carry no reset, so after reset this block also flushes them to bubbles before fetch starts.

Parameters:
- PIPE_DEPTH, 4: number of post-reset INIT cycles during which all stage registers are flushed.
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before a fatal HALT; 0 disables the timeout.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_addr_i  in  5  rs1 of the instruction in ID.
- id_rs2_addr_i  in  5  rs2 of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_mem_read_i  in  1  instruction in EX is a load (reg_src selects memory).
- ex_rd_addr_i  in  5  destination register of the instruction in EX.
- ex_redirect_i  in  1  EX resolved a taken branch or jump.
- mem_req_i  in  1  MEM stage is issuing a load or store this cycle.
- mem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF_ID hold when 0.
- if_id_flush_o  out  1  IF_ID loads a NOP bubble.
- id_ex_write_o  out  1  ID_EX hold when 0.
- id_ex_flush_o  out  1  ID_EX loads a bubble (reg_write=0, mem_write=0).
- ex_mem_write_o  out  1  EX_MEM hold when 0.
- mem_wb_flush_o  out  1  MEM_WB loads a bubble.
- halted_o  out  1  core is halted.
- mem_err_o  out  1  sticky memory-timeout error.
- stall_cnt_o  out  CNT_W  stall cycles (optional feature).
- flush_cnt_o  out  CNT_W  flush events (optional feature).

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0:
  - state=INIT, init counter=0, wait counter=0.
  - pc_write_o=0, all *_write_o=0, all *_flush_o=1, halted_o=0, mem_err_o=0, counters=0.
- Outputs are combinational from the registered state and the current inputs, so a stall takes effect in the same cycle.
- INIT:
  - All flushes=1, all writes=0.
  - After PIPE_DEPTH cycles, go to RUN.
  - First fetch is the cycle after leaving INIT.
- RUN, evaluated in priority order:
  1. Memory wait: mem_req_i=1 and mem_ready_i=0.
     - Freeze: pc/if_id/id_ex/ex_mem writes=0, mem_wb_flush_o=1.
     - Go to MEM_WAIT; wait counter=1.
  2. Redirect: ex_redirect_i=1.
     - if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1.
     - Redirect overrides the load-use stall, because the ID instruction is on the wrong path.
  3. Load-use: ex_mem_read_i=1, ex_rd_addr_i≠0, and (rs1 used and equal) or (rs2 used and equal).
     - pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1.
     - Exactly one bubble is inserted.
  4. Otherwise all writes=1 and all flushes=0.
- MEM_WAIT:
  - While mem_ready_i=0: freeze as in rule 1 and increment the wait counter.
  - Cycle with mem_ready_i=1: evaluate RUN rules 2–4 in the same cycle, clear the counter, go to RUN.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with ready still 0: go to HALT and set mem_err_o.
- HALT:
  - All writes=0, all flushes=1, halted_o=1.
  - Exit only via reset; mem_err_o stays sticky until reset.
- rd=x0 never creates a hazard.
- A mem_ready_i pulse without mem_req_i is ignored.
- Reset asserted mid-MEM_WAIT returns to INIT immediately and asynchronously.
- The wait counter is sized clog2(MEM_TIMEOUT+1), minimum 1 bit.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- When defined:
  - stall_cnt_o increments each RUN/MEM_WAIT cycle with pc_write_o=0.
  - flush_cnt_o increments on each redirect.
  - Both saturate at all-ones and clear on reset.
- When undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared header pipe_ctrl_defs.vh holds:
  - state encodings INIT=2'b00, RUN=2'b01, MEM_WAIT=2'b10, HALT=2'b11;
  - the load reg_src encoding;
  - the x0 constant.
- One combinational sub-module, hazard_detect, performs the load-use comparison and outputs a single load_use flag.

Test Plan:
- Reset release with PIPE_DEPTH=4 → flushes=1 for 4 cycles, then pc_write_o=1; halted_o=0.
- EX load x5, ID uses rs2=x5 → one cycle with pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next cycle all writes=1. Repeat with rd=x0 → no stall.
- ex_redirect_i=1 while load-use also true → if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1; no stall.
- mem_req_i=1, mem_ready_i low 3 cycles then high → 3 freeze cycles with mem_wb_flush_o=1; release cycle all writes=1; stall_cnt_o=3 with PIPE_CTRL_PERF_CNT_EN.
- MEM_TIMEOUT=8, ready never asserted → HALT after 8 wait cycles, mem_err_o=1 and halted_o=1 held; rst_n pulse clears both and re-enters INIT.
- rst_n dropped mid-MEM_WAIT → all outputs reach reset values without waiting for a clk edge.
